// File: rtl/control_step_sequencer_if.sv
// Control-step sequencer bus: run/stop/memory handshake inputs, one-hot T-step and status outputs.
// master drives the requests and observes status; slave is the sequencer itself.
interface control_step_sequencer_if #(
    parameter int NUM_STEPS = 8,
    parameter int CNT_W     = 32
);
    logic                 run;
    logic                 stop;
    logic                 mem_wait_req;
    logic                 mem_ready;
    logic                 instr_done;
    logic [NUM_STEPS-1:0] T;
    logic [3:0]           step;
    logic                 running;
    logic                 stalled;
    logic                 timeout;
    logic [CNT_W-1:0]     instr_count;

    modport master (
        output run, stop, mem_wait_req, mem_ready, instr_done,
        input  T, step, running, stalled, timeout, instr_count
    );

    modport slave (
        input  run, stop, mem_wait_req, mem_ready, instr_done,
        output T, step, running, stalled, timeout, instr_count
    );
endinterface

// File: rtl/control_step_sequencer.sv
// One-hot T-step generator; one step per clock, first step one cycle after run, all outputs registered.
// Holds the step while a memory read is not ready, traps to ERROR after MAX_WAIT stalled cycles.
module control_step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int CNT_W     = 32,
    parameter int MAX_WAIT  = 15
) (
    input logic                     clk,
    input logic                     clr,
    control_step_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT, ERROR} state_t;

    localparam logic [NUM_STEPS-1:0] T_FIRST = NUM_STEPS'(1);

    state_t               state;
    logic [3:0]           step_q;
    logic [NUM_STEPS-1:0] t_q;
    logic                 running_q;
    logic                 stalled_q;
    logic                 timeout_q;
    logic [CNT_W-1:0]     count_q;
    logic [7:0]           wait_cnt;
    logic                 stop_pending;

    logic       go;
    logic       last_step;
    logic       stop_req;
    logic [3:0] step_nxt;

    // go: this edge advances the step, either unstalled in RUN or on the ready edge in WAIT
    assign go        = ((state == RUN) && !(bus.mem_wait_req && !bus.mem_ready)) ||
                       ((state == WAIT) && bus.mem_ready);
    assign last_step = bus.instr_done || (step_q == 4'(NUM_STEPS - 1));
    assign stop_req  = bus.stop || stop_pending;
    assign step_nxt  = step_q + 4'd1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            step_q       <= '0;
            t_q          <= '0;
            running_q    <= 1'b0;
            stalled_q    <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            wait_cnt     <= '0;
            stop_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state     <= RUN;
                        step_q    <= '0;
                        t_q       <= T_FIRST;
                        running_q <= 1'b1;
                    end
                end
                RUN, WAIT: begin
                    if (go) begin
                        state     <= RUN;
                        stalled_q <= 1'b0;
                        wait_cnt  <= '0;
                        if (last_step) begin
                            count_q <= count_q + CNT_W'(1);
                            step_q  <= '0;
                            if (stop_req) begin
                                state        <= IDLE;
                                t_q          <= '0;
                                running_q    <= 1'b0;
                                stop_pending <= 1'b0;
                            end else begin
                                t_q <= T_FIRST;
                            end
                        end else begin
                            step_q <= step_nxt;
                            t_q    <= T_FIRST << step_nxt;
                            if (bus.stop) stop_pending <= 1'b1;
                        end
                    end else if (state == RUN) begin
                        state     <= WAIT;
                        stalled_q <= 1'b1;
                        wait_cnt  <= 8'd1;
                        if (bus.stop) stop_pending <= 1'b1;
                    end else if (wait_cnt == 8'(MAX_WAIT)) begin
                        state        <= ERROR;
                        step_q       <= '0;
                        t_q          <= '0;
                        running_q    <= 1'b0;
                        stalled_q    <= 1'b0;
                        timeout_q    <= 1'b1;
                        wait_cnt     <= '0;
                        stop_pending <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (bus.stop) stop_pending <= 1'b1;
                    end
                end
                default: ; // ERROR is left only through clr
            endcase
        end
    end

    assign bus.T           = t_q;
    assign bus.step        = step_q;
    assign bus.running     = running_q;
    assign bus.stalled     = stalled_q;
    assign bus.timeout     = timeout_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer with default parameters.
module tb_control_step_sequencer;
    logic clk;
    logic clr;
    int   errors;
    int   checks;

    control_step_sequencer_if #(.NUM_STEPS(8), .CNT_W(32)) bus ();

    control_step_sequencer #(.NUM_STEPS(8), .CNT_W(32), .MAX_WAIT(15)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clr = 1'b0;
        bus.run = 1'b0; bus.stop = 1'b0; bus.mem_wait_req = 1'b0;
        bus.mem_ready = 1'b0; bus.instr_done = 1'b0;
        #2;
        clr = 1'b1;
        tick();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        bus.run = 1'b0; bus.stop = 1'b0; bus.mem_wait_req = 1'b0;
        bus.mem_ready = 1'b0; bus.instr_done = 1'b0;
        #3;
        checks++; if (bus.T !== 8'h00) begin errors++; $display("FAIL reset_T: got %h expected 00", bus.T); end
        checks++; if (bus.step !== 4'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", bus.step); end
        checks++; if ({bus.running, bus.stalled, bus.timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.running, bus.stalled, bus.timeout}); end
        checks++; if (bus.instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.instr_count); end
        @(negedge clk);
        clr = 1'b1;
        tick(); tick();
        checks++; if (bus.T !== 8'h00 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_hold: got T=%h running=%b expected T=00 running=0", bus.T, bus.running); end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_t;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        checks++; if (bus.T !== 8'h01 || bus.running !== 1'b1) begin errors++; $display("FAIL start_T: got T=%h running=%b expected T=01 running=1", bus.T, bus.running); end
        for (int i = 1; i < 8; i++) begin
            tick();
            exp_t = 8'h01 << i;
            checks++; if (bus.T !== exp_t || bus.step !== 4'(i)) begin errors++; $display("FAIL free_step%0d: got T=%h step=%0d expected T=%h step=%0d", i, bus.T, bus.step, exp_t, i); end
        end
        tick();
        checks++; if (bus.T !== 8'h01 || bus.instr_count !== 32'd1) begin errors++; $display("FAIL wrap1: got T=%h count=%0d expected T=01 count=1", bus.T, bus.instr_count); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (bus.T !== 8'h01 || bus.instr_count !== 32'd2) begin errors++; $display("FAIL wrap2: got T=%h count=%0d expected T=01 count=2", bus.T, bus.instr_count); end
    endtask

    task automatic test_early_end();
        logic [7:0] exp_t;
        restart();
        for (int rep = 0; rep < 3; rep++) begin
            for (int s = 1; s < 4; s++) begin
                tick();
                exp_t = 8'h01 << s;
                checks++; if (bus.T !== exp_t) begin errors++; $display("FAIL early_rep%0d_step%0d: got T=%h expected %h", rep, s, bus.T, exp_t); end
            end
            bus.instr_done = 1'b1;
            tick();
            bus.instr_done = 1'b0;
            checks++; if (bus.T !== 8'h01 || bus.instr_count !== 32'(rep + 1)) begin errors++; $display("FAIL early_end%0d: got T=%h count=%0d expected T=01 count=%0d", rep, bus.T, bus.instr_count, rep + 1); end
        end
    endtask

    task automatic test_stall();
        restart();
        tick();
        bus.mem_wait_req = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.T !== 8'h02 || bus.stalled !== 1'b1 || bus.running !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got T=%h stalled=%b running=%b expected T=02 stalled=1 running=1", i, bus.T, bus.stalled, bus.running); end
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_wait_req = 1'b0;
        bus.mem_ready = 1'b0;
        checks++; if (bus.T !== 8'h04 || bus.stalled !== 1'b0) begin errors++; $display("FAIL stall_release: got T=%h stalled=%b expected T=04 stalled=0", bus.T, bus.stalled); end
        tick();
        checks++; if (bus.T !== 8'h08 || bus.instr_count !== 32'd0) begin errors++; $display("FAIL stall_after: got T=%h count=%0d expected T=08 count=0", bus.T, bus.instr_count); end
    endtask

    task automatic test_timeout();
        restart();
        tick(); tick();
        bus.mem_wait_req = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (bus.T !== 8'h04 || bus.stalled !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got T=%h stalled=%b timeout=%b expected T=04 stalled=1 timeout=0", bus.T, bus.stalled, bus.timeout); end
        tick();
        checks++; if (bus.T !== 8'h00 || bus.timeout !== 1'b1 || bus.running !== 1'b0 || bus.stalled !== 1'b0) begin errors++; $display("FAIL timeout_trap: got T=%h timeout=%b running=%b stalled=%b expected T=00 timeout=1 running=0 stalled=0", bus.T, bus.timeout, bus.running, bus.stalled); end
        bus.mem_wait_req = 1'b0;
        bus.run = 1'b1;
        tick(); tick();
        bus.run = 1'b0;
        checks++; if (bus.T !== 8'h00 || bus.timeout !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL error_sticky: got T=%h timeout=%b running=%b expected T=00 timeout=1 running=0", bus.T, bus.timeout, bus.running); end
        clr = 1'b0;
        #2;
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", bus.timeout); end
        clr = 1'b1;
    endtask

    task automatic test_deferred_stop();
        restart();
        tick(); tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if (bus.T !== 8'h08) begin errors++; $display("FAIL stop_cont8: got T=%h expected 08", bus.T); end
        tick();
        checks++; if (bus.T !== 8'h10) begin errors++; $display("FAIL stop_cont10: got T=%h expected 10", bus.T); end
        tick();
        checks++; if (bus.T !== 8'h20) begin errors++; $display("FAIL stop_cont20: got T=%h expected 20", bus.T); end
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        checks++; if (bus.T !== 8'h00 || bus.running !== 1'b0 || bus.instr_count !== 32'd1) begin errors++; $display("FAIL stop_halt: got T=%h running=%b count=%0d expected T=00 running=0 count=1", bus.T, bus.running, bus.instr_count); end
        tick();
        checks++; if (bus.T !== 8'h00) begin errors++; $display("FAIL stop_idle: got T=%h expected 00", bus.T); end
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        checks++; if (bus.T !== 8'h01 || bus.running !== 1'b1) begin errors++; $display("FAIL stop_restart: got T=%h running=%b expected T=01 running=1", bus.T, bus.running); end
        tick();
        checks++; if (bus.T !== 8'h02) begin errors++; $display("FAIL stop_restart_step: got T=%h expected 02", bus.T); end
    endtask

    task automatic test_reset_mid_stall();
        restart();
        for (int i = 0; i < 9; i++) tick();
        bus.mem_wait_req = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        checks++; if (bus.T !== 8'h02 || bus.stalled !== 1'b1 || bus.instr_count !== 32'd1) begin errors++; $display("FAIL midstall_pre: got T=%h stalled=%b count=%0d expected T=02 stalled=1 count=1", bus.T, bus.stalled, bus.instr_count); end
        #2;
        clr = 1'b0;
        #1;
        checks++; if (bus.T !== 8'h00 || bus.step !== 4'd0 || bus.stalled !== 1'b0 || bus.running !== 1'b0 || bus.instr_count !== 32'd0) begin errors++; $display("FAIL midstall_clr: got T=%h step=%0d stalled=%b running=%b count=%0d expected all zero", bus.T, bus.step, bus.stalled, bus.running, bus.instr_count); end
        bus.mem_wait_req = 1'b0;
        #1;
        clr = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.T !== 8'h00 || bus.running !== 1'b0 || bus.stalled !== 1'b0) begin errors++; $display("FAIL midstall_idle: got T=%h running=%b stalled=%b expected T=00 running=0 stalled=0", bus.T, bus.running, bus.stalled); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_free_run();
        test_early_end();
        test_stall();
        test_timeout();
        test_deferred_stop();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
